// File: rtl/alu_serial.sv
// Multi-cycle ALU: processes a WIDTH-bit NOR/XOR/ADD/SUB CHUNK bits per clock, LSB slice first,
// with valid/ready handshakes on both sides and zero / signed-overflow flags.
module alu_serial #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(N - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

  localparam logic [1:0] OP_NOR = 2'b00;
  localparam logic [1:0] OP_XOR = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc;
  logic [1:0]       op_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt;

  logic [31:0]      shamt;
  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK-1:0] b_eff_sl;
  logic [CHUNK:0]   sum;
  logic [CHUNK-1:0] res_sl;
  logic             carry_sl;
  logic [WIDTH-1:0] full_res;
  logic             b_eff_msb;
  logic             ovf_nxt;
  logic             last_slice;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign last_slice = (cnt == LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = BUSY;
      BUSY:    if (last_slice) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slice datapath; the finished slice is merged into the partial result so the
  // full word (and its flags) is available at the edge that completes it.
  always_comb begin
    shamt    = 32'(CHUNK) * 32'(cnt);
    a_sl     = CHUNK'(a_r >> shamt);
    b_sl     = CHUNK'(b_r >> shamt);
    b_eff_sl = (op_r == OP_SUB) ? ~b_sl : b_sl;
    sum      = {1'b0, a_sl} + {1'b0, b_eff_sl} + {{CHUNK{1'b0}}, carry_r};
    res_sl   = '0;
    carry_sl = 1'b0;
    case (op_r)
      OP_NOR: res_sl = ~(a_sl | b_sl);
      OP_XOR: res_sl = a_sl ^ b_sl;
      default: begin
        res_sl   = sum[CHUNK-1:0];
        carry_sl = sum[CHUNK];
      end
    endcase
    full_res  = (acc & ~(SLICE_MASK << shamt)) | (WIDTH'(res_sl) << shamt);
    b_eff_msb = b_r[WIDTH-1] ^ (op_r == OP_SUB);
    ovf_nxt   = op_r[1] && (a_r[WIDTH-1] == b_eff_msb) && (full_res[WIDTH-1] != a_r[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      op_r    <= OP_NOR;
      carry_r <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      s       <= '0;
      cout    <= 1'b0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            op_r    <= op;
            carry_r <= cin;
            cnt     <= '0;
          end
        end
        BUSY: begin
          acc     <= full_res;
          carry_r <= carry_sl;
          cnt     <= cnt + CNT_W'(1);
          // Visible outputs change only when the whole word is done.
          if (last_slice) begin
            s    <= full_res;
            cout <= carry_sl;
            zero <= (full_res == '0);
            ovf  <= ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial: four instances (CHUNK 8, 64, 1, 16) driven with directed and
// random operations, checked against a plain-arithmetic reference model.
module tb_alu_serial;

  localparam int W  = 64;
  localparam int NI = 4;

  logic         clk = 1'b0;
  logic         resetn;
  logic         in_valid  [NI];
  logic         in_ready  [NI];
  logic         cin       [NI];
  logic [1:0]   op        [NI];
  logic [W-1:0] a         [NI];
  logic [W-1:0] b         [NI];
  logic         out_valid [NI];
  logic         out_ready [NI];
  logic [W-1:0] s         [NI];
  logic         cout      [NI];
  logic         zero      [NI];
  logic         ovf       [NI];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_serial #(.WIDTH(W), .CHUNK(8)) u_c8 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .cin(cin[0]), .op(op[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .s(s[0]), .cout(cout[0]), .zero(zero[0]), .ovf(ovf[0])
  );

  alu_serial #(.WIDTH(W), .CHUNK(64)) u_c64 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .cin(cin[1]), .op(op[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .s(s[1]), .cout(cout[1]), .zero(zero[1]), .ovf(ovf[1])
  );

  alu_serial #(.WIDTH(W), .CHUNK(1)) u_c1 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2]), .b(b[2]), .cin(cin[2]), .op(op[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .s(s[2]), .cout(cout[2]), .zero(zero[2]), .ovf(ovf[2])
  );

  alu_serial #(.WIDTH(W), .CHUNK(16)) u_c16 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .a(a[3]), .b(b[3]), .cin(cin[3]), .op(op[3]), .out_valid(out_valid[3]),
    .out_ready(out_ready[3]), .s(s[3]), .cout(cout[3]), .zero(zero[3]), .ovf(ovf[3])
  );

  function automatic int n_of(input int idx);
    case (idx)
      0:       return 8;
      1:       return 1;
      2:       return 64;
      default: return 4;
    endcase
  endfunction

  // Returns {cout, zero, ovf, s}.
  function automatic logic [W+2:0] ref_alu(input logic [1:0] o, input logic [W-1:0] av,
                                           input logic [W-1:0] bv, input logic ci);
    logic [W:0]   wide;
    logic [W-1:0] bb;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    bb = (o == 2'b11) ? ~bv : bv;
    c  = 1'b0;
    v  = 1'b0;
    case (o)
      2'b00:   r = ~(av | bv);
      2'b01:   r = av ^ bv;
      default: begin
        wide = {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, ci};
        r    = wide[W-1:0];
        c    = wide[W];
        v    = (av[W-1] == bb[W-1]) && (r[W-1] != av[W-1]);
      end
    endcase
    return {c, (r == '0), v, r};
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 64'h7FFF_FFFF_FFFF_FFFF;
      3:       return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic checkReset(input int idx);
    checkOutput("rst_in_ready", in_ready[idx], 1);
    checkOutput("rst_out_valid", out_valid[idx], 0);
    checkOutput("rst_s", s[idx], 0);
    checkOutput("rst_cout", cout[idx], 0);
    checkOutput("rst_zero", zero[idx], 0);
    checkOutput("rst_ovf", ovf[idx], 0);
  endtask

  // One full operation: accept, count latency, check result, hold under backpressure, hand off.
  task automatic applyStimulus(input int idx, input logic [1:0] o, input logic [W-1:0] av,
                               input logic [W-1:0] bv, input logic ci, input int bp);
    logic [W+2:0] r;
    int           n;
    r = ref_alu(o, av, bv, ci);
    n = n_of(idx);
    checkOutput("idle_ready", in_ready[idx], 1);
    in_valid[idx]  = 1'b1;
    op[idx]        = o;
    a[idx]         = av;
    b[idx]         = bv;
    cin[idx]       = ci;
    out_ready[idx] = 1'b0;
    @(posedge clk); #1;
    a[idx]   = {$urandom, $urandom};
    b[idx]   = {$urandom, $urandom};
    op[idx]  = 2'($urandom);
    cin[idx] = 1'($urandom);
    checkOutput("busy_ready", in_ready[idx], 0);
    checkOutput("busy_valid", out_valid[idx], 0);
    for (int e = 1; e <= n; e++) begin
      in_valid[idx] = 1'($urandom);
      @(posedge clk); #1;
      if (e == n - 1) checkOutput("early_valid", out_valid[idx], 0);
    end
    checkOutput("latency_valid", out_valid[idx], 1);
    checkOutput("done_ready", in_ready[idx], 0);
    checkOutput("s", s[idx], r[W-1:0]);
    checkOutput("ovf", ovf[idx], r[W]);
    checkOutput("zero", zero[idx], r[W+1]);
    checkOutput("cout", cout[idx], r[W+2]);
    for (int k = 0; k < bp; k++) begin
      in_valid[idx] = 1'($urandom);
      a[idx]        = {$urandom, $urandom};
      @(posedge clk); #1;
      checkOutput("bp_valid", out_valid[idx], 1);
      checkOutput("bp_ready", in_ready[idx], 0);
      checkOutput("bp_s", s[idx], r[W-1:0]);
      checkOutput("bp_flags", {cout[idx], zero[idx], ovf[idx]}, r[W+2:W]);
    end
    in_valid[idx]  = 1'b0;
    out_ready[idx] = 1'b1;
    @(posedge clk); #1;
    out_ready[idx] = 1'b0;
    checkOutput("handoff_valid", out_valid[idx], 0);
    checkOutput("handoff_ready", in_ready[idx], 1);
    checkOutput("keep_s", s[idx], r[W-1:0]);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0] ro;
    resetn = 1'b0;
    for (int i = 0; i < NI; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      a[i]         = '0;
      b[i]         = '0;
      cin[i]       = 1'b0;
      op[i]        = 2'b00;
    end
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < NI; i++) checkReset(i);

    applyStimulus(0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 0);
    applyStimulus(0, 2'b11, 64'd5, 64'd3, 1'b1, 1);
    applyStimulus(0, 2'b11, 64'd3, 64'd5, 1'b1, 0);
    applyStimulus(0, 2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 2);
    applyStimulus(0, 2'b00, 64'h0, 64'h0, 1'b0, 5);

    // Abort an ADD with reset at its third slice edge.
    in_valid[0] = 1'b1;
    op[0]       = 2'b10;
    a[0]        = 64'h1234_5678_9ABC_DEF0;
    b[0]        = 64'h1111_1111_1111_1111;
    cin[0]      = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    checkReset(0);
    applyStimulus(0, 2'b10, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 0);

    for (int idx = 0; idx < NI; idx++) begin
      for (int t = 0; t < 8; t++) begin
        ro = 2'($urandom);
        applyStimulus(idx, ro, rand_operand(), rand_operand(), 1'($urandom),
                      int'($urandom_range(0, 3)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
